// File: rtl/clk_div_monitor.sv
// Measures the high time, low time and period of an asynchronous divided clock,
// checks each period against an expected value and tracks lock / timeout status.
module clk_div_monitor #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             sig_in,
  input  logic [CNT_W:0]   exp_period,
  input  logic [CNT_W:0]   tol,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period,
  output logic             meas_valid,
  output logic             locked,
  output logic             period_err,
  output logic             timeout,
  output logic [1:0]       dbg_state
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [MW-1:0]    LOCK_MAX = MW'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

  state_t         state;
  logic           s1, s2, s3;
  logic           rise, fall;
  logic [CNT_W-1:0] hcnt, lcnt;
  logic [MW-1:0]  match;
  logic [CNT_W:0] period_next;
  logic [CNT_W:0] diff;
  logic           in_tol;
  logic           sat;

  assign rise        = s2 & ~s3;
  assign fall        = ~s2 & s3;
  assign period_next = {1'b0, hcnt} + {1'b0, lcnt};
  assign diff        = (period_next >= exp_period) ? (period_next - exp_period)
                                                   : (exp_period - period_next);
  assign in_tol      = (diff <= tol);
  assign dbg_state   = state;

  // A saturated counter with no edge this cycle means the signal has stalled.
  always_comb begin
    sat = 1'b0;
    if (state == MEAS_HIGH)
      sat = (hcnt == CNT_MAX) && !fall;
    else if (state != IDLE)
      sat = (lcnt == CNT_MAX) && !rise;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      state      <= IDLE;
      hcnt       <= '0;
      lcnt       <= '0;
      match      <= '0;
      high_cnt   <= '0;
      low_cnt    <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      period_err <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      s1         <= sig_in;
      s2         <= s1;
      s3         <= s2;
      meas_valid <= 1'b0;
      period_err <= 1'b0;

      if (rise)
        hcnt <= CNT_W'(1);
      else if (state == MEAS_HIGH && s2 && hcnt != CNT_MAX)
        hcnt <= hcnt + 1'b1;

      if (fall)
        lcnt <= CNT_W'(1);
      else if ((state == MEAS_LOW || state == WAIT_RISE) && !s2 && lcnt != CNT_MAX)
        lcnt <= lcnt + 1'b1;

      if (sat) begin
        timeout <= 1'b1;
        locked  <= 1'b0;
        match   <= '0;
        state   <= IDLE;
      end else begin
        unique case (state)
          IDLE:      if (fall) state <= WAIT_RISE;
          WAIT_RISE: if (rise) state <= MEAS_HIGH;
          MEAS_HIGH: if (fall) state <= MEAS_LOW;
          MEAS_LOW: begin
            if (rise) begin
              state      <= MEAS_HIGH;
              high_cnt   <= hcnt;
              low_cnt    <= lcnt;
              period     <= period_next;
              meas_valid <= 1'b1;
              timeout    <= 1'b0;
              // Lock is only re-evaluated here, so limit changes land on a measurement.
              if (in_tol) begin
                if (match != LOCK_MAX) match <= match + 1'b1;
                locked <= (match >= LOCK_MAX - 1'b1);
              end else begin
                period_err <= 1'b1;
                match      <= '0;
                locked     <= 1'b0;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: run-length reference model with a per-cycle
// compare process, plus literal checks on logged measurements.
module tb_clk_div_monitor;

  localparam int LOCK = 4;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       sig_in;
  logic [8:0] exp_period, tol;
  logic [7:0] high_cnt, low_cnt;
  logic [8:0] period;
  logic       meas_valid, locked, period_err, timeout;
  logic [1:0] dbg_state;

  clk_div_monitor #(.CNT_W(8), .LOCK_CNT(LOCK)) dut (
    .clk(clk), .reset_L(reset_L), .sig_in(sig_in),
    .exp_period(exp_period), .tol(tol),
    .high_cnt(high_cnt), .low_cnt(low_cnt), .period(period),
    .meas_valid(meas_valid), .locked(locked), .period_err(period_err),
    .timeout(timeout), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Expected outputs; state code 0 idle, 1 wait-rise, 2 high phase, 3 low phase.
  typedef struct {
    int hi; int lo; int per; int mv; int lk; int pe; int to; int st;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   m_prev, run_len, armed, in_high, have_hi, hi_len, match;

  int lg_hi[$], lg_lo[$], lg_per[$], lg_lk[$], lg_pe[$];

  task automatic model_reset();
    exp_q.delete();
    cur.hi = 0; cur.lo = 0; cur.per = 0; cur.mv = 0;
    cur.lk = 0; cur.pe = 0; cur.to = 0; cur.st = 0;
    m_prev = 0; run_len = 0; armed = 0; in_high = 0;
    have_hi = 0; hi_len = 0; match = 0;
  endtask

  // Model: works on run lengths of sig_in as seen at each posedge. The result for
  // sample k is what the outputs must show two edges later.
  initial begin
    exp_t e;
    int   v;
    forever begin
      @(posedge clk);
      if (reset_L) begin
        e = cur;
        e.mv = 0;
        e.pe = 0;
        v = int'(sig_in);
        if (v != m_prev) begin
          if (v == 0) begin
            if (armed == 0) armed = 1;
            else if (in_high != 0) begin hi_len = run_len; have_hi = 1; end
            in_high = 0;
          end else begin
            if (armed != 0 && have_hi != 0) begin
              int d;
              e.mv  = 1;
              e.hi  = hi_len;
              e.lo  = run_len;
              e.per = hi_len + run_len;
              e.to  = 0;
              d = e.per - int'(exp_period);
              if (d < 0) d = -d;
              if (d <= int'(tol)) begin
                if (match < LOCK) match++;
                e.lk = (match == LOCK) ? 1 : 0;
              end else begin
                e.pe = 1;
                match = 0;
                e.lk = 0;
              end
            end
            if (armed != 0) in_high = 1;
          end
          run_len = 1;
        end else begin
          run_len++;
          if (armed != 0 && run_len == 256) begin
            e.to = 1; e.lk = 0; match = 0;
            armed = 0; in_high = 0; have_hi = 0;
          end
        end
        m_prev = v;
        e.st = (armed == 0) ? 0 : ((in_high != 0) ? 2 : ((have_hi != 0) ? 3 : 1));
        cur = e;
        exp_q.push_back(e);
      end
    end
  end

  // Compare process and measurement log.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_L) begin
        chk("rst_high_cnt", int'(high_cnt), 0);
        chk("rst_low_cnt", int'(low_cnt), 0);
        chk("rst_period", int'(period), 0);
        chk("rst_meas_valid", int'(meas_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_period_err", int'(period_err), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_state", int'(dbg_state), 0);
      end else begin
        if (meas_valid) begin
          lg_hi.push_back(int'(high_cnt));
          lg_lo.push_back(int'(low_cnt));
          lg_per.push_back(int'(period));
          lg_lk.push_back(int'(locked));
          lg_pe.push_back(int'(period_err));
        end
        if (exp_q.size() >= 3) begin
          e = exp_q.pop_front();
          chk("high_cnt", int'(high_cnt), e.hi);
          chk("low_cnt", int'(low_cnt), e.lo);
          chk("period", int'(period), e.per);
          chk("meas_valid", int'(meas_valid), e.mv);
          chk("locked", int'(locked), e.lk);
          chk("period_err", int'(period_err), e.pe);
          chk("timeout", int'(timeout), e.to);
          chk("state", int'(dbg_state), e.st);
        end
      end
    end
  end

  // Drive a level for n sampling posedges; entered and left at posedge+2.
  task automatic set_for(input logic lv, input int n);
    sig_in = lv;
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic per(input int h, input int l);
    set_for(1'b1, h);
    set_for(1'b0, l);
  endtask

  initial begin
    sig_in = 1'b0;
    exp_period = 9'd5;
    tol = 9'd0;
    reset_L = 1'b1;
    model_reset();
    #1 reset_L = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_L = 1'b1;

    // Nominal 3/2 periods until lock.
    set_for(1'b0, 4);
    for (int i = 0; i < 6; i++) per(3, 2);

    // One long period breaks lock, then relock.
    per(3, 4);
    for (int i = 0; i < 5; i++) per(3, 2);

    // Tolerance 1: one bad period, then alternating 4 and 6.
    tol = 9'd1;
    per(3, 7);
    for (int i = 0; i < 4; i++) begin per(2, 2); per(3, 3); end

    // Stall low until timeout, then resume.
    set_for(1'b0, 300);
    chk("to_set", int'(timeout), 1);
    chk("to_unlocked", int'(locked), 0);
    chk("to_idle", int'(dbg_state), 0);
    chk("to_no_valid", lg_hi.size(), 19);
    for (int i = 0; i < 4; i++) per(3, 2);
    chk("to_cleared", int'(timeout), 0);
    chk("to_resume_log", lg_hi.size(), 21);

    // Reset in the middle of a high phase.
    sig_in = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset_L = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_period", int'(period), 0);
    chk("mid_rst_high", int'(high_cnt), 0);
    chk("mid_rst_state", int'(dbg_state), 0);
    repeat (2) begin @(posedge clk); #2; end
    reset_L = 1'b1;
    set_for(1'b1, 1);
    set_for(1'b0, 2);
    per(3, 2);
    chk("rst_no_early_valid", lg_hi.size(), 21);
    per(3, 2);
    chk("rst_first_valid", lg_hi.size(), 22);
    per(3, 2);

    // Mod-5 divider with 50% duty: edges land mid-cycle on alternate clock halves.
    for (int i = 0; i < 12; i++) begin
      sig_in = 1'b1; #25;
      sig_in = 1'b0; #25;
    end
    per(3, 2);
    set_for(1'b0, 8);

    chk("log_size", lg_hi.size(), 36);
    if (lg_hi.size() == 36) begin
      chk("s1_high", lg_hi[0], 3);
      chk("s1_low", lg_lo[0], 2);
      chk("s1_period", lg_per[0], 5);
      chk("s1_lock3", lg_lk[2], 0);
      chk("s1_lock4", lg_lk[3], 1);
      chk("s2_period", lg_per[5], 7);
      chk("s2_low", lg_lo[5], 4);
      chk("s2_err", lg_pe[5], 1);
      chk("s2_unlock", lg_lk[5], 0);
      chk("s2_relock3", lg_lk[8], 0);
      chk("s2_relock4", lg_lk[9], 1);
      chk("s3_bad_period", lg_per[11], 10);
      chk("s3_bad_err", lg_pe[11], 1);
      chk("s3_p4", lg_per[12], 4);
      chk("s3_p4_err", lg_pe[12], 0);
      chk("s3_p6", lg_per[13], 6);
      chk("s3_p6_err", lg_pe[13], 0);
      chk("s3_lock3", lg_lk[14], 0);
      chk("s3_lock4", lg_lk[15], 1);
      chk("s4_period", lg_per[19], 5);
      chk("s4_lock", lg_lk[19], 0);
      chk("s5_high", lg_hi[21], 3);
      chk("s5_low", lg_lo[21], 2);
      chk("s6_lock3", lg_lk[23], 0);
      chk("s6_lock4", lg_lk[24], 1);
      for (int i = 24; i < 36; i++) begin
        chk("div_period", lg_per[i], 5);
        chk("div_high_range", (lg_hi[i] == 2 || lg_hi[i] == 3) ? 1 : 0, 1);
        chk("div_sum", lg_hi[i] + lg_lo[i], 5);
        chk("div_err", lg_pe[i], 0);
      end
    end
    chk("final_locked", int'(locked), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_div_monitor.md
CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of the high-time and low-time counters.
REQ-002 Parameter LOCK_CNT, default 4: number of consecutive in-tolerance periods required to assert locked.
REQ-003 Ports:
- clk  input  1  sole clock; all state updates on posedge clk.
- reset_L  input  1  asynchronous, active-low reset.
REQ-004 Ports:
- sig_in  input  1  divided-clock signal under test, treated as asynchronous.
- exp_period  input  CNT_W+1  expected period in clk cycles.
- tol  input  CNT_W+1  allowed absolute deviation from exp_period.
REQ-005 Ports:
- high_cnt  output  CNT_W  clk cycles sig_in was high in the last complete period.
- low_cnt  output  CNT_W  clk cycles sig_in was low in the last complete period.
- period  output  CNT_W+1  high_cnt + low_cnt.
REQ-006 Ports:
- meas_valid  output  1  one-cycle pulse when high_cnt, low_cnt and period update.
- locked  output  1  level, high when the period matches exp_period.
- period_err  output  1  one-cycle pulse on an out-of-tolerance period.
- timeout  output  1  level, high when a counter has saturated.

Function
REQ-007 sig_in SHALL pass through a 2-flop synchronizer (s1, s2); s3 is s2 delayed one cycle; rise = s2 & ~s3; fall = ~s2 & s3.
REQ-008 States SHALL be IDLE, WAIT_RISE, MEAS_HIGH and MEAS_LOW, with these transitions:
- IDLE -> WAIT_RISE on fall.
- WAIT_RISE -> MEAS_HIGH on rise.
- MEAS_HIGH -> MEAS_LOW on fall.
- MEAS_LOW -> MEAS_HIGH on rise.
REQ-009 The internal hcnt SHALL load 1 on rise and increment, saturating at 2^CNT_W-1, each cycle s2=1 in MEAS_HIGH.
REQ-010 The internal lcnt SHALL load 1 on fall and increment, saturating at 2^CNT_W-1, each cycle s2=0 in MEAS_LOW and WAIT_RISE.
REQ-011 On rise in MEAS_LOW, the block SHALL register on the same edge:
- high_cnt = hcnt and low_cnt = lcnt.
- period = hcnt + lcnt, computed at CNT_W+1 bits with no overflow.
- meas_valid = 1 for exactly one cycle.
REQ-012 A rise in WAIT_RISE SHALL NOT assert meas_valid; the first meas_valid SHALL come at the second rise after the first post-reset fall.
REQ-013 Latency: with sig_in changing between clk edges, meas_valid SHALL be high in the cycle after the 3rd posedge following the sig_in rise.
REQ-014 On each meas_valid, the period SHALL be checked: in tolerance when |period - exp_period| <= tol, computed without wrap.
REQ-015 When in tolerance, an internal match counter SHALL increment, saturating at LOCK_CNT; locked SHALL assert in the cycle the counter reaches LOCK_CNT.
REQ-016 When out of tolerance, on the same edge as meas_valid:
- period_err = 1 for one cycle.
- match counter = 0.
- locked = 0.
REQ-017 When hcnt or lcnt reaches 2^CNT_W-1 (no edge seen), the block SHALL on the next edge:
- set timeout = 1.
- clear locked and the match counter.
- enter IDLE.
meas_valid SHALL NOT assert for that period.
REQ-018 timeout SHALL clear on the next meas_valid.
REQ-019 If exp_period or tol changes, the change SHALL take effect at the next meas_valid only; locked SHALL NOT be re-evaluated in between.
REQ-020 rise and fall cannot coincide; one-cycle sig_in glitches that are captured SHALL be measured as real periods of count 1.

Reset
REQ-021 While reset_L=0, asynchronously:
- s1, s2, s3 = 0.
- state = IDLE.
- hcnt, lcnt, match counter = 0.
- high_cnt, low_cnt, period = 0.
- meas_valid, locked, period_err, timeout = 0.
REQ-022 Reset asserted mid-measurement SHALL discard the partial period; after release, measurement SHALL restart per REQ-012.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset release, sig_in with high 3 / low 2 cycles, exp_period=5, tol=0 -> first meas_valid at 2nd rise after 1st fall; high_cnt=3, low_cnt=2, period=5; locked=1 on the 4th valid.
- Locked at period 5, then one period of high 3 / low 4 -> period=7, period_err pulse, locked=0; 4 further 5-cycle periods -> locked=1 again.
- exp_period=5, tol=1, alternating periods 4 and 6 -> no period_err; locked after 4 valids.
- sig_in held low for 300 cycles, CNT_W=8 -> timeout=1 once lcnt=255, locked=0, state IDLE; resume 5-cycle toggling -> timeout clears at next meas_valid.
- reset_L pulsed low mid-high-phase -> all outputs 0 immediately; next meas_valid only after fall then two rises.
- sig_in from a mod-5 divider with 50% duty -> period=5 every valid; high_cnt in {2,3}; high_cnt+low_cnt=5.
